// File: rtl/fizzbuzz_checker.sv
// fizzbuzz_checker: consumer-side monitor for a FizzBuzz beat stream.
//
// It tracks the expected sequence 1..g_length with mod-3/mod-5 residue counters.
// It latches the first failing beat with a cause code and the received number.
// It pulses o_done on each clean completed pass, and counts clean passes.
// Optional fizz/buzz/fizzbuzz statistics are built only when FIZZBUZZ_STATS_EN
// is defined. Otherwise those ports are tied to 0.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_clear             clear errors/statistics, back to idle (beat in same cycle dropped)
//   i_valid             beat qualifier
//   i_number            received number
//   i_is_fizz/i_is_buzz received flags
//   o_err               sticky error flag
//   o_err_code          first-error cause {buzz, fizz, number}
//   o_err_number        i_number of the first failing beat
//   o_done              one-cycle pulse per clean pass
//   o_pass_cnt          clean passes, saturating
//   o_fizz_cnt, o_buzz_cnt, o_fizzbuzz_cnt  statistics, saturating
module fizzbuzz_checker #(
  parameter int unsigned g_length = 100,
  parameter int unsigned g_cnt_w  = 16,
  localparam int unsigned W       = $clog2(g_length + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_valid,
  input  logic [W-1:0]       i_number,
  input  logic               i_is_fizz,
  input  logic               i_is_buzz,
  output logic               o_err,
  output logic [2:0]         o_err_code,
  output logic [W-1:0]       o_err_number,
  output logic               o_done,
  output logic [g_cnt_w-1:0] o_pass_cnt,
  output logic [g_cnt_w-1:0] o_fizz_cnt,
  output logic [g_cnt_w-1:0] o_buzz_cnt,
  output logic [g_cnt_w-1:0] o_fizzbuzz_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StError} state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       exp_q, exp_d;
  logic [1:0]         r3_q, r3_d;
  logic [2:0]         r5_q, r5_d;
  logic               err_q, err_d;
  logic [2:0]         err_code_q, err_code_d;
  logic [W-1:0]       err_number_q, err_number_d;
  logic               done_q, done_d;
  logic [g_cnt_w-1:0] pass_cnt_q, pass_cnt_d;

  logic [2:0] beat_err;
  logic       beat_live;
  logic       beat_ok;

  assign beat_err  = {(i_is_buzz != (r5_q == 3'd0)),
                      (i_is_fizz != (r3_q == 2'd0)),
                      (i_number != exp_q)};
  // A beat is only looked at outside ERROR and when not being cleared.
  assign beat_live = i_valid && !i_clear && (state_q != StError);
  assign beat_ok   = beat_live && (beat_err == 3'b000);

  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    r3_d         = r3_q;
    r5_d         = r5_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    err_number_d = err_number_q;
    done_d       = 1'b0;
    pass_cnt_d   = pass_cnt_q;

    if (i_clear) begin
      state_d      = StIdle;
      exp_d        = W'(1);
      r3_d         = 2'd1;
      r5_d         = 3'd1;
      err_d        = 1'b0;
      err_code_d   = 3'b000;
      err_number_d = '0;
      pass_cnt_d   = '0;
    end else if (beat_live && !beat_ok) begin
      state_d      = StError;
      err_d        = 1'b1;
      err_code_d   = beat_err;
      err_number_d = i_number;
    end else if (beat_ok) begin
      state_d = StRun;
      if (exp_q == W'(g_length)) begin
        exp_d  = W'(1);
        r3_d   = 2'd1;
        r5_d   = 3'd1;
        done_d = 1'b1;
        if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + g_cnt_w'(1);
      end else begin
        exp_d = exp_q + W'(1);
        r3_d  = (r3_q == 2'd2) ? 2'd0 : r3_q + 2'd1;
        r5_d  = (r5_q == 3'd4) ? 3'd0 : r5_q + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      exp_q        <= W'(1);
      r3_q         <= 2'd1;
      r5_q         <= 3'd1;
      err_q        <= 1'b0;
      err_code_q   <= 3'b000;
      err_number_q <= '0;
      done_q       <= 1'b0;
      pass_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      r3_q         <= r3_d;
      r5_q         <= r5_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      err_number_q <= err_number_d;
      done_q       <= done_d;
      pass_cnt_q   <= pass_cnt_d;
    end
  end

  assign o_err        = err_q;
  assign o_err_code   = err_code_q;
  assign o_err_number = err_number_q;
  assign o_done       = done_q;
  assign o_pass_cnt   = pass_cnt_q;

`ifdef FIZZBUZZ_STATS_EN
  logic [g_cnt_w-1:0] fizz_cnt_q, fizz_cnt_d;
  logic [g_cnt_w-1:0] buzz_cnt_q, buzz_cnt_d;
  logic [g_cnt_w-1:0] fizzbuzz_cnt_q, fizzbuzz_cnt_d;

  always_comb begin
    fizz_cnt_d     = fizz_cnt_q;
    buzz_cnt_d     = buzz_cnt_q;
    fizzbuzz_cnt_d = fizzbuzz_cnt_q;
    if (i_clear) begin
      fizz_cnt_d     = '0;
      buzz_cnt_d     = '0;
      fizzbuzz_cnt_d = '0;
    end else if (beat_ok) begin
      // A fizzbuzz beat counts only as fizzbuzz, not as fizz or buzz.
      if (i_is_fizz && i_is_buzz) begin
        if (fizzbuzz_cnt_q != '1) fizzbuzz_cnt_d = fizzbuzz_cnt_q + g_cnt_w'(1);
      end else if (i_is_fizz) begin
        if (fizz_cnt_q != '1) fizz_cnt_d = fizz_cnt_q + g_cnt_w'(1);
      end else if (i_is_buzz) begin
        if (buzz_cnt_q != '1) buzz_cnt_d = buzz_cnt_q + g_cnt_w'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fizz_cnt_q     <= '0;
      buzz_cnt_q     <= '0;
      fizzbuzz_cnt_q <= '0;
    end else begin
      fizz_cnt_q     <= fizz_cnt_d;
      buzz_cnt_q     <= buzz_cnt_d;
      fizzbuzz_cnt_q <= fizzbuzz_cnt_d;
    end
  end

  assign o_fizz_cnt     = fizz_cnt_q;
  assign o_buzz_cnt     = buzz_cnt_q;
  assign o_fizzbuzz_cnt = fizzbuzz_cnt_q;
`else
  assign o_fizz_cnt     = '0;
  assign o_buzz_cnt     = '0;
  assign o_fizzbuzz_cnt = '0;
`endif

endmodule

// File: tb/tb_fizzbuzz_checker.sv
module tb_fizzbuzz_checker;
  localparam int unsigned Len = 15;
  localparam int unsigned CntW = 16;
  localparam int unsigned W = 4;
`ifdef FIZZBUZZ_STATS_EN
  localparam int Stats = 1;
`else
  localparam int Stats = 0;
`endif

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic            i_clear = 1'b0;
  logic            i_valid = 1'b0;
  logic [W-1:0]    i_number = '0;
  logic            i_is_fizz = 1'b0;
  logic            i_is_buzz = 1'b0;
  logic            o_err;
  logic [2:0]      o_err_code;
  logic [W-1:0]    o_err_number;
  logic            o_done;
  logic [CntW-1:0] o_pass_cnt;
  logic [CntW-1:0] o_fizz_cnt;
  logic [CntW-1:0] o_buzz_cnt;
  logic [CntW-1:0] o_fizzbuzz_cnt;

  fizzbuzz_checker #(
    .g_length(Len),
    .g_cnt_w (CntW)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clear       (i_clear),
    .i_valid       (i_valid),
    .i_number      (i_number),
    .i_is_fizz     (i_is_fizz),
    .i_is_buzz     (i_is_buzz),
    .o_err         (o_err),
    .o_err_code    (o_err_code),
    .o_err_number  (o_err_number),
    .o_done        (o_done),
    .o_pass_cnt    (o_pass_cnt),
    .o_fizz_cnt    (o_fizz_cnt),
    .o_buzz_cnt    (o_buzz_cnt),
    .o_fizzbuzz_cnt(o_fizzbuzz_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit is_done;
    int pass;
    int code;
    int num;
    int fz;
    int bz;
    int fb;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails = 0;
  int done_seen = 0;
  logic err_prev = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_done(input int pass, input int fz, input int bz, input int fb);
    exp_t e;
    e.is_done = 1'b1; e.pass = pass; e.code = 0; e.num = 0;
    e.fz = fz * Stats; e.bz = bz * Stats; e.fb = fb * Stats;
    sb.push_back(e);
  endtask

  task automatic push_err(input int code, input int num);
    exp_t e;
    e.is_done = 1'b0; e.pass = 0; e.code = code; e.num = num;
    e.fz = 0; e.bz = 0; e.fb = 0;
    sb.push_back(e);
  endtask

  // Monitor: every o_done pulse and every rising o_err consumes one scoreboard entry.
  always @(negedge i_clk) begin
    exp_t e;
    if (o_done) begin
      done_seen++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("event_is_done", 1, int'(e.is_done));
        check("done_pass_cnt", int'(o_pass_cnt), e.pass);
        check("done_fizz_cnt", int'(o_fizz_cnt), e.fz);
        check("done_buzz_cnt", int'(o_buzz_cnt), e.bz);
        check("done_fizzbuzz_cnt", int'(o_fizzbuzz_cnt), e.fb);
      end
    end
    if (o_err && !err_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_err", 1, 0);
      end else begin
        e = sb.pop_front();
        check("event_is_err", 0, int'(e.is_done));
        check("err_code", int'(o_err_code), e.code);
        check("err_number", int'(o_err_number), e.num);
      end
    end
    err_prev = o_err;
  end

  task automatic drive(input int n, input bit f, input bit b, input bit v);
    @(posedge i_clk);
    #1;
    i_valid = v; i_number = W'(n); i_is_fizz = f; i_is_buzz = b;
  endtask

  task automatic good(input int n);
    drive(n, (n % 3) == 0, (n % 5) == 0, 1'b1);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b1; i_valid = 1'b0; i_clear = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    done_seen = 0;
  endtask

  initial begin
    // Reset state
    do_reset();
    idle(1);
    @(negedge i_clk);
    check("rst_err", int'(o_err), 0);
    check("rst_err_code", int'(o_err_code), 0);
    check("rst_err_number", int'(o_err_number), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_pass_cnt", int'(o_pass_cnt), 0);
    check("rst_fizz_cnt", int'(o_fizz_cnt), 0);

    // Clean pass 1..15
    push_done(1, 4, 2, 1);
    for (int n = 1; n <= 15; n++) good(n);
    idle(2);
    check("clean_pass_cnt", int'(o_pass_cnt), 1);
    check("clean_err", int'(o_err), 0);
    check("clean_done_pulses", done_seen, 1);

    // Two passes with random gaps
    do_reset();
    push_done(1, 4, 2, 1);
    push_done(2, 8, 4, 2);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      good((i % 15) + 1);
    end
    idle(2);
    check("gaps_pass_cnt", int'(o_pass_cnt), 2);
    check("gaps_done_pulses", done_seen, 2);
    check("gaps_err", int'(o_err), 0);

    // Fizz flag error on beat 6, later beats ignored
    do_reset();
    push_err(3'b010, 6);
    for (int n = 1; n <= 5; n++) good(n);
    drive(6, 1'b0, 1'b0, 1'b1);
    for (int n = 7; n <= 15; n++) good(n);
    idle(2);
    check("flag_err", int'(o_err), 1);
    check("flag_err_code", int'(o_err_code), 2);
    check("flag_err_number", int'(o_err_number), 6);
    check("flag_fizz_frozen", int'(o_fizz_cnt), Stats);
    check("flag_buzz_frozen", int'(o_buzz_cnt), Stats);
    check("flag_fizzbuzz_frozen", int'(o_fizzbuzz_cnt), 0);
    check("flag_pass_cnt", int'(o_pass_cnt), 0);
    check("flag_no_done", done_seen, 0);

    // Clear with a concurrent beat while in ERROR: beat dropped, next 1..15 clean
    @(posedge i_clk);
    #1;
    i_clear = 1'b1; i_valid = 1'b1; i_number = W'(1); i_is_fizz = 1'b0; i_is_buzz = 1'b0;
    @(posedge i_clk);
    #1;
    i_clear = 1'b0; i_valid = 1'b0;
    @(negedge i_clk);
    check("clr_err", int'(o_err), 0);
    check("clr_err_code", int'(o_err_code), 0);
    check("clr_err_number", int'(o_err_number), 0);
    check("clr_fizz_cnt", int'(o_fizz_cnt), 0);
    check("clr_buzz_cnt", int'(o_buzz_cnt), 0);
    push_done(1, 4, 2, 1);
    for (int n = 1; n <= 15; n++) good(n);
    idle(2);
    check("clr_pass_cnt", int'(o_pass_cnt), 1);
    check("clr_err_after", int'(o_err), 0);

    // Reset at beat 8 abandons the pass
    do_reset();
    for (int n = 1; n <= 7; n++) good(n);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1; i_valid = 1'b1; i_number = W'(8); i_is_fizz = 1'b0; i_is_buzz = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0; i_valid = 1'b0;
    push_done(1, 4, 2, 1);
    for (int n = 1; n <= 15; n++) good(n);
    idle(2);
    check("rst_mid_done_pulses", done_seen, 1);
    check("rst_mid_pass_cnt", int'(o_pass_cnt), 1);
    check("rst_mid_err", int'(o_err), 0);

    // Wrong start: first beat is 2
    do_reset();
    push_err(3'b001, 2);
    drive(2, 1'b0, 1'b0, 1'b1);
    idle(2);
    check("start_err", int'(o_err), 1);
    check("start_err_code", int'(o_err_code), 1);

    // Beat 5 sent as 7 without the buzz flag that exp=5 requires: number and buzz fail
    do_reset();
    push_err(3'b101, 7);
    for (int n = 1; n <= 4; n++) good(n);
    drive(7, 1'b0, 1'b0, 1'b1);
    idle(2);
    check("comb_err_code", int'(o_err_code), 5);
    check("comb_err_number", int'(o_err_number), 7);

    // Error on the final beat: error path, no done, no pass count
    do_reset();
    push_err(3'b010, 15);
    for (int n = 1; n <= 14; n++) good(n);
    drive(15, 1'b0, 1'b1, 1'b1);
    idle(2);
    check("last_err_code", int'(o_err_code), 2);
    check("last_no_done", done_seen, 0);
    check("last_pass_cnt", int'(o_pass_cnt), 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
